// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch front end that closes the loop with an external PC
// register. The current pc is fetched over a req/ack memory port, the word is
// presented downstream on a valid/ready handshake, and next_pc is driven back
// so the PC register (which has no enable) can load it on every clock edge.
// Redirects (branch/jump) override everything except reset. A misaligned pc or
// a memory that never answers parks the unit in a sticky error state.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] pc,
    output logic [31:0] next_pc,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    input  logic        redirect,
    input  logic [31:0] redirect_target,

    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,

    output logic        fetch_err
);

    // The timeout counter only ever needs to hold 0 .. TIMEOUT-1.
    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic [31:0]   instr_q;
    logic [31:0]   instr_d;
    logic [31:0]   instr_pc_q;
    logic [31:0]   instr_pc_d;

    logic          pcAligned;
    logic          ackTaken;
    logic          holdAccept;

    // A fetch is only legal from a word-aligned address.
    assign pcAligned  = (pc[1:0] == 2'b00);

    // An ack only captures data when no redirect wants the slot; a redirect in
    // the same cycle means the returned word belongs to a discarded path.
    assign ackTaken   = (state_q == FETCH) && pcAligned && imem_ack && !redirect;

    // Downstream takes the held instruction; the PC may advance.
    assign holdAccept = (state_q == HOLD) && instr_ready;

    // The memory always sees the current pc; imem_req qualifies it.
    assign imem_addr  = pc;

    // State register: reset lands in FETCH so the first cycle after reset
    // release is already a fetch of RESET_PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: redirect wins over ack, accept and error.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!pcAligned) begin
                        state_d = ERR;
                    end else if (imem_ack) begin
                        state_d = HOLD;
                    end else if (count_q == CNT_LAST) begin
                        state_d = ERR;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_d = FETCH;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // Outputs decoded purely from the current state (plus alignment for req),
    // so a misaligned pc never reaches the memory even for one cycle.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        case (state_q)
            FETCH:   imem_req    = pcAligned;
            HOLD:    instr_valid = 1'b1;
            ERR:     fetch_err   = 1'b1;
            default: imem_req    = 1'b0;
        endcase
    end

    // Timeout counter: counts FETCH cycles spent waiting for an ack and is
    // cleared whenever the fetch resolves, errors out or is redirected.
    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else if (state_q == FETCH) begin
            if (!pcAligned || imem_ack || (count_q == CNT_LAST)) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = '0;
        end
    end

    // Instruction capture: the word and its address are frozen on the ack so
    // they stay stable for however long downstream stalls in HOLD.
    always_comb begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (ackTaken) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            count_q    <= count_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign instr    = instr_q;
    assign instr_pc = instr_pc_q;

    // next_pc feeds an enable-less PC register, so "stall" means handing the
    // current pc straight back. Reset overrides combinationally so the PC
    // register loads RESET_PC while reset_n is held low. pc+4 wraps naturally.
    always_comb begin
        next_pc = pc;
        if (!reset_n) begin
            next_pc = RESET_PC;
        end else if (redirect) begin
            next_pc = redirect_target;
        end else if (holdAccept) begin
            next_pc = pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit. The bench owns the PC register (loads next_pc
// every rising edge) and plays the instruction memory by hand. Inputs change
// just after the falling edge; outputs are sampled 1ns later, well clear of
// the rising edge.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc = 32'h0;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_err;

    int tests_run  = 0;
    int fail_count = 0;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc              (pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .fetch_err       (fetch_err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // The PC register that closes the loop: no enable, loads next_pc always.
    always @(posedge clk) pc <= next_pc;

    // Reset values, and reset overriding a simultaneous redirect on next_pc.
    task automatic test_reset();
        reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_target = '0; instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h0000_1234;
        #1;
        tests_run++; if (next_pc !== RESET_PC) begin fail_count++; $display("[TB] FAIL reset_next_pc: got %h, expected %h", next_pc, RESET_PC); end
        tests_run++; if (instr_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_valid: got %b, expected 0", instr_valid); end
        tests_run++; if (instr !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_instr: got %h, expected 0", instr); end
        tests_run++; if (instr_pc !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_instr_pc: got %h, expected 0", instr_pc); end
        tests_run++; if (fetch_err !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_err: got %b, expected 0", fetch_err); end
        redirect = 1'b0; redirect_target = '0;
    endtask

    // Reset release with ack in the first FETCH cycle: pc walks 0, 4, 8.
    task automatic test_basic_fetch();
        @(negedge clk);
        reset_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
        #1;
        tests_run++; if (imem_req !== 1'b1) begin fail_count++; $display("[TB] FAIL basic_req0: got %b, expected 1", imem_req); end
        tests_run++; if (imem_addr !== 32'h0) begin fail_count++; $display("[TB] FAIL basic_addr0: got %h, expected 0", imem_addr); end
        tests_run++; if (next_pc !== 32'h0) begin fail_count++; $display("[TB] FAIL basic_stall0: got %h, expected 0", next_pc); end
        tests_run++; if (instr_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL basic_valid_early: got %b, expected 0", instr_valid); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        tests_run++; if (instr_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL basic_valid: got %b, expected 1", instr_valid); end
        tests_run++; if (instr !== 32'hAAAA_0001) begin fail_count++; $display("[TB] FAIL basic_instr: got %h, expected aaaa0001", instr); end
        tests_run++; if (instr_pc !== 32'h0) begin fail_count++; $display("[TB] FAIL basic_instr_pc: got %h, expected 0", instr_pc); end
        tests_run++; if (next_pc !== 32'h4) begin fail_count++; $display("[TB] FAIL basic_next4: got %h, expected 4", next_pc); end
        tests_run++; if (imem_req !== 1'b0) begin fail_count++; $display("[TB] FAIL basic_req_hold: got %b, expected 0", imem_req); end
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0002;
        #1;
        tests_run++; if (pc !== 32'h4) begin fail_count++; $display("[TB] FAIL basic_pc4: got %h, expected 4", pc); end
        tests_run++; if (imem_addr !== 32'h4) begin fail_count++; $display("[TB] FAIL basic_addr4: got %h, expected 4", imem_addr); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        tests_run++; if (instr !== 32'hAAAA_0002) begin fail_count++; $display("[TB] FAIL basic_instr2: got %h, expected aaaa0002", instr); end
        tests_run++; if (instr_pc !== 32'h4) begin fail_count++; $display("[TB] FAIL basic_instr_pc2: got %h, expected 4", instr_pc); end
        tests_run++; if (next_pc !== 32'h8) begin fail_count++; $display("[TB] FAIL basic_next8: got %h, expected 8", next_pc); end
    endtask

    // Ack three cycles late: req held four cycles, pc stalls, one valid pulse.
    task automatic test_ack_delay();
        int valids = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ack = (i == 3); imem_rdata = 32'h0BAD_C0DE;
            #1;
            valids += int'(instr_valid);
            tests_run++; if (imem_req !== 1'b1) begin fail_count++; $display("[TB] FAIL delay_req[%0d]: got %b, expected 1", i, imem_req); end
            tests_run++; if (next_pc !== 32'h8) begin fail_count++; $display("[TB] FAIL delay_stall[%0d]: got %h, expected 8", i, next_pc); end
        end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        valids += int'(instr_valid);
        tests_run++; if (instr !== 32'h0BAD_C0DE) begin fail_count++; $display("[TB] FAIL delay_instr: got %h, expected 0badc0de", instr); end
        tests_run++; if (next_pc !== 32'hC) begin fail_count++; $display("[TB] FAIL delay_next: got %h, expected c", next_pc); end
        @(negedge clk);
        #1;
        valids += int'(instr_valid);
        tests_run++; if (valids !== 1) begin fail_count++; $display("[TB] FAIL delay_pulses: got %0d, expected 1", valids); end
    endtask

    // Downstream stalls 5 cycles in HOLD; data stays put, pc stalls.
    task automatic test_hold_stall();
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_0003; instr_ready = 1'b0;
        #1;
        tests_run++; if (imem_addr !== 32'hC) begin fail_count++; $display("[TB] FAIL stall_addr: got %h, expected c", imem_addr); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
            #1;
            tests_run++; if (instr_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL stall_valid[%0d]: got %b, expected 1", i, instr_valid); end
            tests_run++; if (instr !== 32'hCAFE_0003) begin fail_count++; $display("[TB] FAIL stall_instr[%0d]: got %h, expected cafe0003", i, instr); end
            tests_run++; if (instr_pc !== 32'hC) begin fail_count++; $display("[TB] FAIL stall_instr_pc[%0d]: got %h, expected c", i, instr_pc); end
            tests_run++; if (next_pc !== 32'hC) begin fail_count++; $display("[TB] FAIL stall_next[%0d]: got %h, expected c", i, next_pc); end
        end
        @(negedge clk);
        instr_ready = 1'b1;
        #1;
        tests_run++; if (next_pc !== 32'h10) begin fail_count++; $display("[TB] FAIL stall_accept: got %h, expected 10", next_pc); end
    endtask

    // Redirect in the same cycle as an ack: the ack data must be dropped.
    task automatic test_redirect_ack();
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_DEAD;
        redirect = 1'b1; redirect_target = 32'h100;
        #1;
        tests_run++; if (next_pc !== 32'h100) begin fail_count++; $display("[TB] FAIL redir_next: got %h, expected 100", next_pc); end
        @(negedge clk);
        imem_ack = 1'b0; redirect = 1'b0;
        #1;
        tests_run++; if (instr_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL redir_no_valid: got %b, expected 0", instr_valid); end
        tests_run++; if (imem_req !== 1'b1) begin fail_count++; $display("[TB] FAIL redir_req: got %b, expected 1", imem_req); end
        tests_run++; if (imem_addr !== 32'h100) begin fail_count++; $display("[TB] FAIL redir_addr: got %h, expected 100", imem_addr); end
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hBEEF_0100;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        tests_run++; if (instr !== 32'hBEEF_0100) begin fail_count++; $display("[TB] FAIL redir_instr: got %h, expected beef0100", instr); end
        tests_run++; if (instr_pc !== 32'h100) begin fail_count++; $display("[TB] FAIL redir_instr_pc: got %h, expected 100", instr_pc); end
        tests_run++; if (next_pc !== 32'h104) begin fail_count++; $display("[TB] FAIL redir_next2: got %h, expected 104", next_pc); end
    endtask

    // Misaligned redirect parks in ERR; an aligned redirect recovers.
    task automatic test_misaligned();
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        tests_run++; if (imem_req !== 1'b0) begin fail_count++; $display("[TB] FAIL mis_req_first: got %b, expected 0", imem_req); end
        tests_run++; if (fetch_err !== 1'b0) begin fail_count++; $display("[TB] FAIL mis_err_first: got %b, expected 0", fetch_err); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tests_run++; if (fetch_err !== 1'b1) begin fail_count++; $display("[TB] FAIL mis_err[%0d]: got %b, expected 1", i, fetch_err); end
            tests_run++; if (imem_req !== 1'b0) begin fail_count++; $display("[TB] FAIL mis_req[%0d]: got %b, expected 0", i, imem_req); end
            tests_run++; if (next_pc !== 32'h102) begin fail_count++; $display("[TB] FAIL mis_next[%0d]: got %h, expected 102", i, next_pc); end
        end
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h200;
        #1;
        tests_run++; if (next_pc !== 32'h200) begin fail_count++; $display("[TB] FAIL mis_redir_next: got %h, expected 200", next_pc); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        tests_run++; if (fetch_err !== 1'b0) begin fail_count++; $display("[TB] FAIL mis_err_clear: got %b, expected 0", fetch_err); end
        tests_run++; if (imem_req !== 1'b1) begin fail_count++; $display("[TB] FAIL mis_req_resume: got %b, expected 1", imem_req); end
        tests_run++; if (imem_addr !== 32'h200) begin fail_count++; $display("[TB] FAIL mis_addr_resume: got %h, expected 200", imem_addr); end
    endtask

    // TIMEOUT cycles with no ack: error only after the last one.
    task automatic test_timeout();
        int early = 0;
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h300;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            redirect = 1'b0;
            #1;
            if (fetch_err !== 1'b0 || imem_req !== 1'b1) early++;
        end
        tests_run++; if (early !== 0) begin fail_count++; $display("[TB] FAIL timeout_early: got %0d bad cycles, expected 0", early); end
        @(negedge clk);
        #1;
        tests_run++; if (fetch_err !== 1'b1) begin fail_count++; $display("[TB] FAIL timeout_err: got %b, expected 1", fetch_err); end
        tests_run++; if (imem_req !== 1'b0) begin fail_count++; $display("[TB] FAIL timeout_req: got %b, expected 0", imem_req); end
        tests_run++; if (next_pc !== 32'h300) begin fail_count++; $display("[TB] FAIL timeout_next: got %h, expected 300", next_pc); end
    endtask

    // Accepting the instruction at 0xFFFF_FFFC wraps next_pc to zero.
    task automatic test_wrap();
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678; instr_ready = 1'b0;
        #1;
        tests_run++; if (imem_addr !== 32'hFFFF_FFFC) begin fail_count++; $display("[TB] FAIL wrap_addr: got %h, expected fffffffc", imem_addr); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        tests_run++; if (next_pc !== 32'hFFFF_FFFC) begin fail_count++; $display("[TB] FAIL wrap_stall: got %h, expected fffffffc", next_pc); end
        @(negedge clk);
        instr_ready = 1'b1;
        #1;
        tests_run++; if (next_pc !== 32'h0) begin fail_count++; $display("[TB] FAIL wrap_next: got %h, expected 0", next_pc); end
        tests_run++; if (instr_pc !== 32'hFFFF_FFFC) begin fail_count++; $display("[TB] FAIL wrap_instr_pc: got %h, expected fffffffc", instr_pc); end
    endtask

    // Reset asserted mid-HOLD clears instr_valid without waiting for a clock.
    task automatic test_reset_mid_hold();
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h55AA_55AA; instr_ready = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        tests_run++; if (instr_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL rst_hold_valid: got %b, expected 1", instr_valid); end
        reset_n = 1'b0; redirect = 1'b1; redirect_target = 32'h40;
        #1;
        tests_run++; if (instr_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_hold_drop: got %b, expected 0", instr_valid); end
        tests_run++; if (instr !== 32'h0) begin fail_count++; $display("[TB] FAIL rst_hold_instr: got %h, expected 0", instr); end
        tests_run++; if (next_pc !== RESET_PC) begin fail_count++; $display("[TB] FAIL rst_hold_next: got %h, expected %h", next_pc, RESET_PC); end
        redirect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs the scenarios in order and prints the summary.
    initial begin
        test_reset();
        test_basic_fetch();
        test_ack_delay();
        test_hold_stall();
        test_redirect_ack();
        test_misaligned();
        test_timeout();
        test_wrap();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

    // Guard against the run never reaching its end.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
